// File: rtl/encoder_round_scheduler.sv
// Round/stage sequencer for the encoder: issues each stage unit in turn, STAGES per round,
// for ROUNDS rounds, and supplies round index and ping-pong bank select to the datapath.
module encoder_round_scheduler #(
   parameter int ROUNDS = 24,
   parameter int STAGES = 5,
   parameter int RW     = 5,
   parameter int SW     = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [STAGES-1:0] stg_ready,
   output logic [STAGES-1:0] stg_start,
   output logic [SW-1:0]     stage_sel,
   output logic [RW-1:0]     round_idx,
   output logic              bank_sel,
   output logic              ready,
   output logic              done
);

   typedef enum logic [2:0] {
      S_IDLE, S_ISSUE, S_ACK, S_BUSY, S_NEXT, S_DONE
   } state_t;

   localparam logic [SW-1:0] LAST_STAGE = SW'(STAGES - 1);
   localparam logic [RW-1:0] LAST_ROUND = RW'(ROUNDS - 1);

   state_t          state_q, state_d;
   logic [SW-1:0]   stage_q, stage_d;
   logic [RW-1:0]   round_q, round_d;
   logic            bank_q, bank_d;
   logic            sel_ready;

   // Only the currently selected stage's ready bit steers the sequence.
   assign sel_ready = stg_ready[stage_q];

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         stage_q <= '0;
         round_q <= '0;
         bank_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         stage_q <= stage_d;
         round_q <= round_d;
         bank_q  <= bank_d;
      end
   end

   always_comb begin
      state_d = state_q;
      stage_d = stage_q;
      round_d = round_q;
      bank_d  = bank_q;
      case (state_q)
         S_IDLE: begin
            if (start && !abort) begin
               state_d = S_ISSUE;
               stage_d = '0;
               round_d = '0;
               bank_d  = 1'b0;
            end
         end
         S_ISSUE: if (sel_ready)  state_d = S_ACK;
         S_ACK:   if (!sel_ready) state_d = S_BUSY;
         S_BUSY:  if (sel_ready)  state_d = S_NEXT;
         S_NEXT: begin
            bank_d = ~bank_q;
            // The final stage of the final round leaves the counters parked for DONE.
            if (stage_q == LAST_STAGE) begin
               if (round_q == LAST_ROUND) begin
                  state_d = S_DONE;
               end else begin
                  stage_d = '0;
                  round_d = round_q + 1'b1;
                  state_d = S_ISSUE;
               end
            end else begin
               stage_d = stage_q + 1'b1;
               state_d = S_ISSUE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (abort && (state_q != S_IDLE)) begin
         state_d = S_IDLE;
         stage_d = '0;
         round_d = '0;
         bank_d  = 1'b0;
      end
   end

   always_comb begin
      ready     = (state_q == S_IDLE);
      done      = (state_q == S_DONE);
      stg_start = '0;
      if ((state_q == S_ISSUE) && sel_ready) begin
         stg_start[stage_q] = 1'b1;
      end
   end

   assign stage_sel = stage_q;
   assign round_idx = round_q;
   assign bank_sel  = bank_q;

endmodule
